mips_mc_control: RTL

- Multicycle MIPS control unit; the DUT-side counterpart that consumes the instruction and zero flag the bench drives/monitors and produces p_state plus all datapath enables.
- Moore FSM (one instruction = 3-5 states), ALU decoder, PCEn logic, retired-instruction counter and illegal-instruction flag.
- Sits between instruction register and datapath; the datapath holds Instr stable from DECODE until the instruction's last state.

---
 rtl/mips_mc_control.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/mips_mc_control.sv
`default_nettype none
// ============================================================================
// Module   : mips_mc_control
// Purpose  : Multicycle MIPS control unit. A Moore FSM steps each
//            instruction through 3-5 states and drives the datapath enables.
//            It also contains the ALU decoder, the PC-enable logic, a
//            retired-instruction counter and an illegal-instruction flag.
// Ports    : clk        - system clock, all state on posedge
//            reset      - asynchronous active-low reset
//            Instr      - current instruction (opcode [31:26], funct [5:0])
//            zero       - ALU zero flag, used only in BRANCH
//            p_state    - current FSM state encoding
//            PCEn, IRWrite, MemWrite, RegWrite, IorD, MemtoReg, RegDst,
//            ALUSrcA, ALUSrcB, PCSrc, ALUControl - datapath controls
//            illegal    - one-cycle pulse on unsupported opcode/funct
//            retired    - count of completed instructions (wraps)
// Revision : 1.0 - initial release
// ============================================================================
module mips_mc_control #(
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       Instr,
  input  logic              zero,
  output logic [3:0]        p_state,
  output logic              PCEn,
  output logic              IRWrite,
  output logic              MemWrite,
  output logic              RegWrite,
  output logic              IorD,
  output logic              MemtoReg,
  output logic              RegDst,
  output logic              ALUSrcA,
  output logic [1:0]        ALUSrcB,
  output logic [1:0]        PCSrc,
  output logic [2:0]        ALUControl,
  output logic              illegal,
  output logic [CNT_W-1:0]  retired
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  localparam logic [5:0] c_OP_RTYPE = 6'h00;
  localparam logic [5:0] c_OP_J     = 6'h02;
  localparam logic [5:0] c_OP_BEQ   = 6'h04;
  localparam logic [5:0] c_OP_ADDI  = 6'h08;
  localparam logic [5:0] c_OP_LW    = 6'h23;
  localparam logic [5:0] c_OP_SW    = 6'h2B;

  state_t       r_state;
  state_t       w_next;
  logic [CNT_W-1:0] r_retired;

  logic         w_pcwrite;
  logic         w_branch;
  logic         w_irwrite;
  logic         w_memwrite;
  logic         w_regwrite;
  logic         w_iord;
  logic         w_memtoreg;
  logic         w_regdst;
  logic         w_alusrca;
  logic [1:0]   w_alusrcb;
  logic [1:0]   w_pcsrc;
  logic [2:0]   w_aluctl;
  logic         w_illegal;
  logic         w_retire;

  wire [5:0] w_op    = Instr[31:26];
  wire [5:0] w_funct = Instr[5:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = S_FETCH;
    w_pcwrite  = 1'b0;
    w_branch   = 1'b0;
    w_irwrite  = 1'b0;
    w_memwrite = 1'b0;
    w_regwrite = 1'b0;
    w_iord     = 1'b0;
    w_memtoreg = 1'b0;
    w_regdst   = 1'b0;
    w_alusrca  = 1'b0;
    w_alusrcb  = 2'b00;
    w_pcsrc    = 2'b00;
    w_aluctl   = 3'b010;
    w_illegal  = 1'b0;
    w_retire   = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_alusrcb = 2'b01;
        w_irwrite = 1'b1;
        w_pcwrite = 1'b1;
        w_next    = S_DECODE;
      end
      S_DECODE: begin
        w_alusrcb = 2'b11;
        case (w_op)
          c_OP_LW, c_OP_SW: w_next = S_MEMADR;
          c_OP_RTYPE:       w_next = S_EXECUTE;
          c_OP_BEQ:         w_next = S_BRANCH;
          c_OP_ADDI:        w_next = S_ADDIEX;
          c_OP_J:           w_next = S_JUMP;
          default:          w_illegal = 1'b1;
        endcase
      end
      S_MEMADR: begin
        w_alusrca = 1'b1;
        w_alusrcb = 2'b10;
        // Only lw/sw reach here; anything but lw is treated as a store.
        w_next    = (w_op == c_OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        w_iord = 1'b1;
        w_next = S_MEMWB;
      end
      S_MEMWB: begin
        w_memtoreg = 1'b1;
        w_regwrite = 1'b1;
        w_retire   = 1'b1;
      end
      S_MEMWR: begin
        w_iord     = 1'b1;
        w_memwrite = 1'b1;
        w_retire   = 1'b1;
      end
      S_EXECUTE: begin
        w_alusrca = 1'b1;
        w_next    = S_ALUWB;
        case (w_funct)
          6'h20:   w_aluctl = 3'b010;
          6'h22:   w_aluctl = 3'b110;
          6'h24:   w_aluctl = 3'b000;
          6'h25:   w_aluctl = 3'b001;
          6'h2A:   w_aluctl = 3'b111;
          default: begin
            w_illegal = 1'b1;
            w_next    = S_FETCH;
          end
        endcase
      end
      S_ALUWB: begin
        w_regdst   = 1'b1;
        w_regwrite = 1'b1;
        w_retire   = 1'b1;
      end
      S_BRANCH: begin
        w_alusrca = 1'b1;
        w_aluctl  = 3'b110;
        w_pcsrc   = 2'b01;
        w_branch  = 1'b1;
        w_retire  = 1'b1;
      end
      S_ADDIEX: begin
        w_alusrca = 1'b1;
        w_alusrcb = 2'b10;
        w_next    = S_ADDIWB;
      end
      S_ADDIWB: begin
        w_regwrite = 1'b1;
        w_retire   = 1'b1;
      end
      S_JUMP: begin
        w_pcsrc   = 2'b10;
        w_pcwrite = 1'b1;
        w_retire  = 1'b1;
      end
      default: w_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_retired <= '0;
    end else if (w_retire) begin
      r_retired <= r_retired + CNT_W'(1);
    end
  end

  // Write-type enables are gated by reset so nothing in the datapath can
  // change state while the FSM is held in FETCH.
  assign p_state    = r_state;
  assign PCEn       = reset & (w_pcwrite | (w_branch & zero));
  assign IRWrite    = reset & w_irwrite;
  assign MemWrite   = reset & w_memwrite;
  assign RegWrite   = reset & w_regwrite;
  assign IorD       = w_iord;
  assign MemtoReg   = w_memtoreg;
  assign RegDst     = w_regdst;
  assign ALUSrcA    = w_alusrca;
  assign ALUSrcB    = w_alusrcb;
  assign PCSrc      = w_pcsrc;
  assign ALUControl = w_aluctl;
  assign illegal    = reset & w_illegal;
  assign retired    = r_retired;

endmodule
`default_nettype wire
